// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew: delays each skewed array lane into an aligned
// row, queues rows in a first-word-fall-through FIFO, requests stall.
module systolic_output_deskew #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             CLK,
  input  logic                             SYNC_RST,
  input  logic                             EN,
  input  logic [LANES-1:0]                 In_Valid,
  input  logic [LANES*DATA_WIDTH-1:0]      In_Data,
  output logic                             Out_Valid,
  input  logic                             Out_Ready,
  output logic [LANES*DATA_WIDTH-1:0]      Out_Data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  Fifo_Count,
  output logic                             Stall_Req,
  output logic                             Overflow,
  output logic                             Skew_Err
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH-1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef logic [LANES*DATA_WIDTH-1:0] row_t;

  logic [LANES-1:0] al_vld;
  row_t             al_row;

  // lane i gets LANES-i stages so every lane lands in the same slot
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int D = LANES - i;

    logic [DATA_WIDTH-1:0] dat_q [D];
    logic [DATA_WIDTH-1:0] dat_d [D];
    logic [D-1:0]          vld_q;
    logic [D-1:0]          vld_d;

    always_comb begin
      dat_d = dat_q;
      vld_d = vld_q;
      if (EN) begin
        dat_d[0] = In_Data[i*DATA_WIDTH +: DATA_WIDTH];
        vld_d[0] = In_Valid[i];
        for (int s = 1; s < D; s++) begin
          dat_d[s] = dat_q[s-1];
          vld_d[s] = vld_q[s-1];
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
        dat_q <= '{default: '0};
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign al_vld[i] = vld_q[D-1];
    assign al_row[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[D-1];
  end

  row_t          mem_q [FIFO_DEPTH];
  row_t          mem_d [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          skew_q, skew_d;
  logic          all_v, any_v;
  logic          push_req, push, pop;

  always_comb begin
    all_v    = &al_vld;
    any_v    = |al_vld;
    push_req = EN && all_v;
    pop      = (cnt_q != '0) && Out_Ready;
    // a pop on the same edge frees the slot the push needs
    push     = push_req && ((cnt_q < FULL) || pop);

    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    skew_d = skew_q;

    if (push) begin
      mem_d[wr_q] = al_row;
      wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end
    if (EN && any_v && !all_v) begin
      skew_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      mem_q  <= '{default: '0};
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      skew_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      skew_q <= skew_d;
    end
  end

  assign Out_Valid  = (cnt_q != '0);
  assign Out_Data   = mem_q[rd_q];
  assign Fifo_Count = cnt_q;
  assign Stall_Req  = (FIFO_DEPTH - int'(cnt_q)) < LANES;
  assign Overflow   = ovf_q;
  assign Skew_Err   = skew_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// tb_systolic_output_deskew: table vectors, directed corner sequences and
// random traffic checked against a row-level queue model.
module tb_systolic_output_deskew;

  localparam int L  = 4;
  localparam int W  = 32;
  localparam int DW = L * W;

  logic          clk = 1'b0;
  logic          SYNC_RST = 1'b0;
  logic          EN = 1'b0;
  logic [L-1:0]  In_Valid = '0;
  logic [DW-1:0] In_Data = '0;
  logic          Out_Valid;
  logic          Out_Ready = 1'b0;
  logic [DW-1:0] Out_Data;
  logic [3:0]    Fifo_Count;
  logic          Stall_Req;
  logic          Overflow;
  logic          Skew_Err;

  systolic_output_deskew #(
    .LANES(L), .DATA_WIDTH(W), .FIFO_DEPTH(8)
  ) dut (
    .CLK(clk),
    .SYNC_RST(SYNC_RST),
    .EN(EN),
    .In_Valid(In_Valid),
    .In_Data(In_Data),
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready),
    .Out_Data(Out_Data),
    .Fifo_Count(Fifo_Count),
    .Stall_Req(Stall_Req),
    .Overflow(Overflow),
    .Skew_Err(Skew_Err)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  logic [DW-1:0] mq[$];
  logic          m_ovf, m_skew;
  logic [L-1:0]  hv [L];
  logic [DW-1:0] hd [L];

  logic [DW-1:0] got[$];

  int unsigned row_mask;
  int          late_row, late_lane;
  int          ecnt;

  typedef struct {
    logic [L-1:0]  v;
    logic [DW-1:0] d;
    logic          rdy;
    logic          ev;
    logic [3:0]    cnt;
    logic [DW-1:0] od;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [DW-1:0] pk(int a0, int a1, int a2, int a3);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [DW-1:0] row(int r);
    return pk(10*r, 10*r+1, 10*r+2, 10*r+3);
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: the row pushed at EN edge p is lane i's sample from EN
  // edge p-L+i; hv/hd hold the last L EN-edge samples, oldest first.
  task automatic model_edge(input logic rst, input logic en,
                            input logic [L-1:0] v, input logic [DW-1:0] d,
                            input logic rdy);
    logic          pop, push, all1, any1;
    logic [DW-1:0] r;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_skew = 1'b0;
      for (int j = 0; j < L; j++) begin
        hv[j] = '0;
        hd[j] = '0;
      end
      return;
    end
    pop = (mq.size() > 0) && rdy;
    push = 1'b0;
    if (en) begin
      all1 = 1'b1;
      any1 = 1'b0;
      r = '0;
      for (int i = 0; i < L; i++) begin
        all1 &= hv[i][i];
        any1 |= hv[i][i];
        r[i*W +: W] = hd[i][i*W +: W];
      end
      if (all1) begin
        if (mq.size() < 8 || pop) push = 1'b1;
        else m_ovf = 1'b1;
      end else if (any1) begin
        m_skew = 1'b1;
      end
      for (int j = 0; j < L-1; j++) begin
        hv[j] = hv[j+1];
        hd[j] = hd[j+1];
      end
      hv[L-1] = v;
      hd[L-1] = d;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(r);
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("out_valid", DW'(Out_Valid), DW'(n != 0));
    chk("fifo_count", DW'(Fifo_Count), DW'(n));
    chk("stall_req", DW'(Stall_Req), DW'((8 - n) < L));
    chk("overflow", DW'(Overflow), DW'(m_ovf));
    chk("skew_err", DW'(Skew_Err), DW'(m_skew));
    if (n != 0) chk("out_data", Out_Data, mq[0]);
  endtask

  task automatic step(input logic rst, input logic en,
                      input logic [L-1:0] v, input logic [DW-1:0] d,
                      input logic rdy);
    SYNC_RST = rst;
    EN = en;
    In_Valid = v;
    In_Data = d;
    Out_Ready = rdy;
    if (!rst && Out_Valid && rdy) got.push_back(Out_Data);
    @(posedge clk);
    model_edge(rst, en, v, d, rdy);
    #1;
    check_model();
  endtask

  task automatic plan_in(input int e, output logic [L-1:0] v,
                         output logic [DW-1:0] d);
    int r;
    v = '0;
    d = '0;
    for (int i = 0; i < L; i++) begin
      r = e - i;
      if (i == late_lane && r == late_row) continue;
      if (i == late_lane && r == late_row + 1) r = late_row;
      else if (r < 0 || r > 31 || !row_mask[r]) continue;
      v[i] = 1'b1;
      d[i*W +: W] = 32'(10*r + i);
    end
  endtask

  task automatic feed(input logic en, input logic rdy);
    logic [L-1:0]  v;
    logic [DW-1:0] d;
    if (en) plan_in(ecnt, v, d);
    else begin
      v = L'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
    end
    step(1'b0, en, v, d, rdy);
    if (en) ecnt++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    ecnt = 0;
    late_row = -10;
    late_lane = -1;
    got.delete();
  endtask

  initial begin
    int first, stall_cnt, vcount;
    logic [7:0]    rb_v;
    logic [DW-1:0] rb_d [8];
    logic          en, rdy, rst;
    logic [L-1:0]  v;
    logic [DW-1:0] d;
    int            idx;

    tbl[0] = '{4'h1, pk(0, 0, 0, 0),     1'b1, 1'b0, 4'd0, 128'd0};
    tbl[1] = '{4'h3, pk(10, 1, 0, 0),    1'b1, 1'b0, 4'd0, 128'd0};
    tbl[2] = '{4'h7, pk(20, 11, 2, 0),   1'b1, 1'b0, 4'd0, 128'd0};
    tbl[3] = '{4'hF, pk(30, 21, 12, 3),  1'b1, 1'b0, 4'd0, 128'd0};
    tbl[4] = '{4'hE, pk(0, 31, 22, 13),  1'b1, 1'b1, 4'd1, pk(0, 1, 2, 3)};
    tbl[5] = '{4'hC, pk(0, 0, 32, 23),   1'b1, 1'b1, 4'd1, pk(10, 11, 12, 13)};
    tbl[6] = '{4'h8, pk(0, 0, 0, 33),    1'b1, 1'b1, 4'd1, pk(20, 21, 22, 23)};
    tbl[7] = '{4'h0, pk(0, 0, 0, 0),     1'b1, 1'b1, 4'd1, pk(30, 31, 32, 33)};
    tbl[8] = '{4'h0, pk(0, 0, 0, 0),     1'b1, 1'b0, 4'd0, 128'd0};

    // reset state
    do_reset();
    chk("rst_valid", DW'(Out_Valid), '0);
    chk("rst_count", DW'(Fifo_Count), '0);
    chk("rst_stall", DW'(Stall_Req), '0);
    chk("rst_ovf", DW'(Overflow), '0);
    chk("rst_skew", DW'(Skew_Err), '0);
    chk("rst_data", Out_Data, '0);

    // skewed stream table
    for (int t = 0; t < 9; t++) begin
      step(1'b0, 1'b1, tbl[t].v, tbl[t].d, tbl[t].rdy);
      chk($sformatf("tbl%0d_valid", t), DW'(Out_Valid), DW'(tbl[t].ev));
      chk($sformatf("tbl%0d_count", t), DW'(Fifo_Count), DW'(tbl[t].cnt));
      if (tbl[t].ev) chk($sformatf("tbl%0d_data", t), Out_Data, tbl[t].od);
    end

    // EN frozen for 3 cycles during row 1's skew
    do_reset();
    row_mask = 32'hF;
    first = -1;
    for (int c = 0; c < 20; c++) begin
      feed(!(c >= 3 && c < 6), 1'b1);
      if (first < 0 && Out_Valid) first = c;
    end
    chk("freeze_latency", DW'(first), DW'(7));
    chk("freeze_rows", DW'(got.size()), DW'(4));
    for (int r = 0; r < 4 && r < got.size(); r++)
      chk($sformatf("freeze_row%0d", r), got[r], row(r));

    // backpressure and overflow
    do_reset();
    row_mask = 32'h3FF;
    stall_cnt = -1;
    for (int c = 0; c < 16; c++) begin
      feed(1'b1, 1'b0);
      if (stall_cnt < 0 && Stall_Req) stall_cnt = Fifo_Count;
    end
    chk("bp_stall_at", DW'(stall_cnt), DW'(5));
    chk("bp_count", DW'(Fifo_Count), DW'(8));
    chk("bp_ovf", DW'(Overflow), DW'(1));
    for (int c = 0; c < 12; c++) feed(1'b1, 1'b1);
    chk("bp_drained", DW'(got.size()), DW'(8));
    for (int r = 0; r < 8 && r < got.size(); r++)
      chk($sformatf("bp_row%0d", r), got[r], row(r));

    // full FIFO with push and pop on the same edge
    do_reset();
    row_mask = 32'h1FF;
    for (int c = 0; c < 12; c++) feed(1'b1, 1'b0);
    chk("full_count", DW'(Fifo_Count), DW'(8));
    feed(1'b1, 1'b1);
    chk("pp_count", DW'(Fifo_Count), DW'(8));
    chk("pp_ovf", DW'(Overflow), DW'(0));
    for (int c = 0; c < 10; c++) feed(1'b1, 1'b1);
    chk("pp_rows", DW'(got.size()), DW'(9));
    for (int r = 0; r < 9 && r < got.size(); r++)
      chk($sformatf("pp_row%0d", r), got[r], row(r));

    // lane 2 of row 2 arrives one EN edge late
    do_reset();
    row_mask = 32'h15;
    late_row = 2;
    late_lane = 2;
    for (int c = 0; c < 14; c++) begin
      feed(1'b1, 1'b1);
      if (c == 5) chk("skew_before", DW'(Skew_Err), DW'(0));
    end
    chk("skew_flag", DW'(Skew_Err), DW'(1));
    chk("skew_rows", DW'(got.size()), DW'(2));
    if (got.size() == 2) begin
      chk("skew_row0", got[0], row(0));
      chk("skew_row4", got[1], row(4));
    end

    // reset with 3 rows queued, more in flight, Skew_Err still set
    row_mask = 32'h3F;
    late_row = -10;
    late_lane = -1;
    ecnt = 0;
    for (int c = 0; c < 7; c++) feed(1'b1, 1'b0);
    chk("mr_count_pre", DW'(Fifo_Count), DW'(3));
    chk("mr_skew_pre", DW'(Skew_Err), DW'(1));
    plan_in(ecnt, v, d);
    step(1'b1, 1'b1, v, d, 1'b0);
    chk("mr_valid", DW'(Out_Valid), '0);
    chk("mr_count", DW'(Fifo_Count), '0);
    chk("mr_ovf", DW'(Overflow), '0);
    chk("mr_skew", DW'(Skew_Err), '0);
    vcount = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 1'b1, '0, '0, 1'b1);
      if (Out_Valid) vcount++;
    end
    chk("mr_no_stale", DW'(vcount), '0);

    // random traffic against the model
    do_reset();
    rb_v = '0;
    for (int k = 0; k < 8; k++) rb_d[k] = '0;
    for (int c = 0; c < 2000; c++) begin
      en  = ($urandom_range(99) < 85);
      rdy = ($urandom_range(99) < 60);
      rst = ($urandom_range(999) < 4);
      if (en) begin
        rb_v[ecnt % 8] = ($urandom_range(99) < 80);
        rb_d[ecnt % 8] = {$urandom, $urandom, $urandom, $urandom};
        v = '0;
        d = '0;
        for (int i = 0; i < L; i++) begin
          idx = (ecnt + 8 - i) % 8;
          v[i] = rb_v[idx];
          d[i*W +: W] = rb_d[idx][i*W +: W];
        end
        if ($urandom_range(99) < 3) begin
          idx = $urandom_range(L-1);
          v[idx] = ~v[idx];
        end
        ecnt++;
      end else begin
        v = L'($urandom);
        d = {$urandom, $urandom, $urandom, $urandom};
      end
      step(rst, en, v, d, rdy);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/systolic_output_deskew.md
# systolic_output_deskew

Output-side realignment buffer for the systolic array. Result rows leave the array skewed: lane i of a row arrives i enabled cycles after lane 0. This block delays each lane so that every row is realigned into one word. Aligned rows go into a first-word-fall-through FIFO with a valid/ready handshake toward the writeback path, and the block raises a stall request so the array controller can freeze the array before the FIFO overflows.

## Interface
- LANES, default 4: number of array output lanes; minimum 1.
- DATA_WIDTH, default 32: signed width of each lane element.
- FIFO_DEPTH, default 8: aligned-row FIFO entries; must be at least LANES.

- CLK  input  1  clock; all state changes on the rising edge.
- SYNC_RST  input  1  synchronous active-high reset. It is the only reset and has priority over everything else.
- EN  input  1  shared advance enable with the array. Delay lines and FIFO push act only when EN=1.
- In_Valid  input  LANES  per-lane valid; bit i qualifies lane i.
- In_Data  input  LANES*DATA_WIDTH  packed lane data; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- Out_Valid  output  1  FIFO non-empty.
- Out_Ready  input  1  consumer accepts the head row when Out_Valid=1.
- Out_Data  output  LANES*DATA_WIDTH  FIFO head row, in the same packing as In_Data.
- Fifo_Count  output  $clog2(FIFO_DEPTH+1)  occupied FIFO entries.
- Stall_Req  output  1  high when free entries (FIFO_DEPTH - Fifo_Count) < LANES.
- Overflow  output  1  sticky; set when an aligned row is dropped because the FIFO is full.
- Skew_Err  output  1  sticky; set when an aligned slot has some, but not all, lane valids set.

## Operation
- Per-lane delay line:
  - Lane i passes through LANES-i registers, carrying both data and valid. Lane LANES-1 therefore has 1 register and lane 0 has LANES.
  - All registers shift only when EN=1 and hold when EN=0.
- Aligned slot: the outputs of the last register of every lane.
  - All aligned valids = 1 and EN=1: push the row into the FIFO.
  - Aligned valids mixed, not all 0 and not all 1, with EN=1: no push; set Skew_Err.
  - All aligned valids = 0: no action.
- Push gating:
  - A push happens only on an EN=1 edge, so a frozen aligned slot is never pushed twice.
  - The push is accepted if Fifo_Count < FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the row is dropped and Overflow is set.
- Pop: on any edge with Out_Valid=1 and Out_Ready=1, regardless of EN. Pops with Out_Valid=0 are ignored.
- FIFO ordering and indexing:
  - Strict FIFO order; Out_Data always shows the head entry.
  - Read and write pointers wrap modulo FIFO_DEPTH. Non-power-of-2 depths are supported.
- Fifo_Count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Stall_Req is combinational from the registered count. Upstream must drop EN while it is high; the block does not depend on this for correctness.
- Flags: Overflow and Skew_Err stay set until SYNC_RST.

## Timing
- Reset values:
  - Out_Valid=0, Fifo_Count=0, Overflow=0, Skew_Err=0.
  - Out_Data=0, and the FIFO storage is cleared.
  - Stall_Req = (FIFO_DEPTH < LANES) = 0.
  - All delay registers and valids = 0.
- Reset mid-operation discards every partial row in flight and every FIFO entry. The first edge after reset is released behaves as a normal edge.
- Latency:
  - If lane 0 of a row is sampled at EN edge k and lane i at EN edge k+i, the row is aligned after edge k+LANES-1.
  - It is pushed at edge k+LANES, so Out_Valid=1 after edge k+LANES when the FIFO was empty.
  - With EN low cycles in between, latency counts EN=1 edges only.
- Throughput: one aligned row per EN cycle in, one row per cycle out.
- Pop is visible in the same cycle: Out_Data and Out_Valid update after the pop edge. With FWFT there is no extra read latency.
- Full FIFO with Out_Ready=1 and a push on the same edge: both occur, and Fifo_Count stays at FIFO_DEPTH.

## Test plan
- Skewed stream, LANES=4, EN=1:
  - Stimulus: row lane i = 10*r+i, presented skewed for rows r=0..3, Out_Ready=1.
  - Required: the first Out_Valid appears 4 edges after lane 0 of row 0. Out_Data rows arrive as {0,1,2,3}, {10,11,12,13}, ... on consecutive cycles.
- EN freeze: drop EN for 3 cycles midway through row 1's skew.
  - Required: no duplicate or missing rows, data intact, and latency extended by exactly 3.
- Backpressure, FIFO_DEPTH=8:
  - Stimulus: Out_Ready=0 while feeding 6 rows and ignoring Stall_Req.
  - Required: Stall_Req rises when Fifo_Count reaches 5.
  - Continue to 10 rows: Fifo_Count saturates at 8, Overflow=1, and the dropped rows are rows 8-9.
  - Then Out_Ready=1: rows 0-7 drain in order.
- Full FIFO with simultaneous push and pop:
  - Required: Fifo_Count stays 8, no Overflow, and the new row appears in order.
- Skew error: lane 2 valid arrives one cycle late for one row.
  - Required: that row is not pushed and Skew_Err=1.
- Mid-operation reset: assert SYNC_RST with 3 rows in the FIFO and 2 rows in flight.
  - Required: on the next cycle Out_Valid=0, Fifo_Count=0 and flags=0, and no stale rows are emitted afterward.
